// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display scanner.
//   AN_OFF      : all anodes off (active-low, so all 1s), NUM_DIGITS_MAX wide
//   onehot_low  : active-low one-hot anode pattern for a digit index
package display_pkg;

   localparam int unsigned NUM_DIGITS_MAX = 8;
   localparam int unsigned IDX_MAX_W      = 3;

   localparam logic [NUM_DIGITS_MAX-1:0] AN_OFF = '1;

   // Anode pattern with only digit idx driven low.
   function automatic logic [NUM_DIGITS_MAX-1:0] onehot_low(input logic [IDX_MAX_W-1:0] idx);
      return ~(NUM_DIGITS_MAX'(1) << idx);
   endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Digit-slot timebase: counts 0..REFRESH_DIV-1 and flags the last cycle of each slot.
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   o_cnt          position within the current slot
//   o_slot_end_c   combinational, high on the last cycle of a slot
module refresh_tick_gen #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_slot_end_c
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == CNT_W'(REFRESH_DIV - 1));

   // Free-running slot counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt        = r_cnt;
   assign o_slot_end_c = w_last;

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexes NUM_DIGITS hex digits onto one shared 7-segment decoder,
// one digit per refresh slot, with a dark guard at the start of every slot.
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   digits      digit i = digits[4*i+3:4*i], digit 0 rightmost
//   dp_in       1 = light the decimal point of digit i
//   blank_mask  1 = keep digit i dark
//   hex         registered nibble to the decoder
//   an          registered anodes, active-low
//   dp          registered decimal point, active-low
// Optional feature macro: LEADING_ZERO_BLANK_EN -- darkens leading zero digits
// (digit 0 is always shown).
module display_scan_controller
   import display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 8,
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [3:0]              hex,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    dp
);

   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

   logic [CNT_W-1:0]          w_cnt;
   logic                      w_slot_end;
   logic [IDX_W-1:0]          r_idx;
   logic [NUM_DIGITS-1:0]     w_auto_blank;
   logic [3:0]                w_hex;
   logic                      w_dp_sel;
   logic                      w_mask_sel;
   logic                      w_guard;
   logic                      w_an_on;
   logic [NUM_DIGITS_MAX-1:0] w_onehot;
   logic [3:0]                r_hex;
   logic [NUM_DIGITS-1:0]     r_an;
   logic                      r_dp;

   refresh_tick_gen #(
      .REFRESH_DIV (REFRESH_DIV),
      .CNT_W       (CNT_W)
   ) u_tick (
      .i_clk        (clk),
      .i_rst        (reset),
      .o_cnt        (w_cnt),
      .o_slot_end_c (w_slot_end)
   );

   // Digit index advances once per slot and wraps after the last digit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx <= '0;
      end else if (w_slot_end) begin
         if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
            r_idx <= '0;
         end else begin
            r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is auto-blanked when it and every digit above it are zero.
   always_comb begin
      logic v_zero_above;
      v_zero_above = 1'b1;
      w_auto_blank = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         v_zero_above    = v_zero_above & (digits[4*i +: 4] == 4'h0);
         w_auto_blank[i] = v_zero_above;
      end
   end
`else
   assign w_auto_blank = '0;
`endif

   // Select the live inputs of the digit currently being scanned.
   always_comb begin
      w_hex      = 4'h0;
      w_dp_sel   = 1'b0;
      w_mask_sel = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_hex      = digits[4*i +: 4];
            w_dp_sel   = dp_in[i];
            w_mask_sel = blank_mask[i] | w_auto_blank[i];
         end
      end
   end

   // Anti-ghosting guard at the start of each slot.
   if (BLANK_CYCLES == 0) begin : g_no_guard
      assign w_guard = 1'b0;
   end else begin : g_guard
      assign w_guard = (32'(w_cnt) < BLANK_CYCLES);
   end

   assign w_an_on  = ~w_guard & ~w_mask_sel;
   assign w_onehot = onehot_low(IDX_MAX_W'(r_idx));

   // Output registers; dp is only lit together with its anode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hex <= 4'h0;
         r_an  <= AN_OFF[NUM_DIGITS-1:0];
         r_dp  <= 1'b1;
      end else begin
         r_hex <= w_hex;
         r_an  <= w_an_on ? w_onehot[NUM_DIGITS-1:0] : AN_OFF[NUM_DIGITS-1:0];
         r_dp  <= ~(w_dp_sel & w_an_on);
      end
   end

   assign hex = r_hex;
   assign an  = r_an;
   assign dp  = r_dp;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (8 digits, 4-cycle slots, 1 guard cycle).
// Expected outputs come from the slot/cycle arithmetic of the scan pattern.
module tb_display_scan_controller;

   localparam int unsigned N  = 8;
   localparam int unsigned RD = 4;
   localparam int unsigned BC = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] digits;
   logic [7:0]  dp_in;
   logic [7:0]  blank_mask;
   logic [3:0]  hex;
   logic [7:0]  an;
   logic        dp;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   display_scan_controller #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .digits     (digits),
      .dp_in      (dp_in),
      .blank_mask (blank_mask),
      .hex        (hex),
      .an         (an),
      .dp         (dp)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Digit displayed during output cycle c (1 = first cycle after reset release).
   function automatic int slot_digit(input int c);
      return ((c - 1) / RD) % N;
   endfunction

   function automatic logic lz_dark(input int d);
`ifdef LEADING_ZERO_BLANK_EN
      return (d > 0) && ((digits >> (4 * d)) == 32'h0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] exp_an(input int c);
      int d;
      logic dark;
      d    = slot_digit(c);
      dark = (((c - 1) % RD) < BC) || blank_mask[d] || lz_dark(d);
      return dark ? 8'hFF : ~(8'h01 << d);
   endfunction

   function automatic logic [3:0] exp_hex(input int c);
      return 4'((digits >> (4 * slot_digit(c))) & 32'hF);
   endfunction

   function automatic logic exp_dp(input int c);
      return !(dp_in[slot_digit(c)] && (exp_an(c) != 8'hFF));
   endfunction

   task automatic run_cycles(input string tag, input int c_from, input int c_to);
      for (int c = c_from; c <= c_to; c++) begin
         tick();
         check($sformatf("%s an c%0d", tag, c), 32'(an), 32'(exp_an(c)));
         check($sformatf("%s hex c%0d", tag, c), 32'(hex), 32'(exp_hex(c)));
         check($sformatf("%s dp c%0d", tag, c), 32'(dp), 32'(exp_dp(c)));
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " an"}, 32'(an), 32'hFF);
      check({tag, " hex"}, 32'(hex), 32'h0);
      check({tag, " dp"}, 32'(dp), 32'h1);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      check_reset_vals({tag, " async"});
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals({tag, " held"});
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      digits     = 32'h7654_3210;
      dp_in      = 8'h00;
      blank_mask = 8'h00;

      // Reset value before any clock edge, then held for 3 cycles.
      do_reset("rst");

      // Full scan order 0..7 and wrap back to digit 0.
      run_cycles("scan", 1, 36);

      // Masked digit 7 stays dark but keeps its slot.
      blank_mask = 8'h80;
      do_reset("rst_mask");
      run_cycles("mask", 1, 36);

      // Decimal point only in visible cycles of digit 2.
      blank_mask = 8'h00;
      dp_in      = 8'h04;
      do_reset("rst_dp");
      run_cycles("dp", 1, 32);

      // Asynchronous reset in the middle of slot 5.
      dp_in = 8'h20;
      do_reset("rst_mid");
      run_cycles("pre", 1, 22);
      #2;
      reset = 1'b1;
      #1;
      check_reset_vals("mid async");
      tick();
      check_reset_vals("mid held");
      reset = 1'b0;
      run_cycles("restart", 1, 8);

      // Leading-zero handling (auto-blank only when the feature is built in).
      dp_in  = 8'h00;
      digits = 32'h0000_0305;
      do_reset("rst_lz");
      run_cycles("lz305", 1, 32);
      digits = 32'h0;
      run_cycles("lz0", 33, 64);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
